// File: rtl/fu_ls_pipe.sv
// Load/store functional unit: in-order issue buffer that computes effective
// addresses at dispatch and walks the head entry through LSQ request, load response and completion.
module fu_ls_pipe #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int SQ_IDX_W = 3,
    parameter int TAG_W    = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_is_store,
    input  logic [XLEN-1:0]     in_base,
    input  logic [11:0]         in_imm,
    input  logic [XLEN-1:0]     in_data,
    input  logic [1:0]          in_size,
    input  logic [SQ_IDX_W-1:0] in_sq_pos,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                squash,
    output logic                lsq_req_valid,
    input  logic                lsq_req_ready,
    output logic                lsq_req_store,
    output logic [XLEN-1:0]     lsq_req_addr,
    output logic [XLEN-1:0]     lsq_req_data,
    output logic [1:0]          lsq_req_size,
    output logic [SQ_IDX_W-1:0] lsq_req_sq_pos,
    input  logic                lsq_resp_valid,
    input  logic [XLEN-1:0]     lsq_resp_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [TAG_W-1:0]    res_tag,
    output logic [XLEN-1:0]     res_value,
    output logic                res_is_store
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [XLEN-1:0]    load_data_q, load_data_d;

    logic [DEPTH-1:0]    ent_store_q, ent_store_d;
    logic [XLEN-1:0]     ent_addr_q  [DEPTH];
    logic [XLEN-1:0]     ent_addr_d  [DEPTH];
    logic [XLEN-1:0]     ent_data_q  [DEPTH];
    logic [XLEN-1:0]     ent_data_d  [DEPTH];
    logic [1:0]          ent_size_q  [DEPTH];
    logic [1:0]          ent_size_d  [DEPTH];
    logic [SQ_IDX_W-1:0] ent_sqpos_q [DEPTH];
    logic [SQ_IDX_W-1:0] ent_sqpos_d [DEPTH];
    logic [TAG_W-1:0]    ent_tag_q   [DEPTH];
    logic [TAG_W-1:0]    ent_tag_d   [DEPTH];

    logic               push_s;
    logic               pop_s;
    logic               req_valid_s;
    logic               res_valid_s;
    logic [XLEN-1:0]    eff_addr_s;

    assign in_ready    = (count_q < DEPTH_C);
    assign push_s      = in_valid && in_ready;
    assign pop_s       = (state_q == ST_DONE) && res_ready;
    assign req_valid_s = (state_q == ST_REQ);
    assign res_valid_s = (state_q == ST_DONE);
    assign eff_addr_s  = in_base + {{(XLEN-12){in_imm[11]}}, in_imm};

    // Buffer bookkeeping, entry writes and head FSM; squash wipes everything in-flight.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        load_data_d = load_data_q;
        ent_store_d = ent_store_q;
        ent_addr_d  = ent_addr_q;
        ent_data_d  = ent_data_q;
        ent_size_d  = ent_size_q;
        ent_sqpos_d = ent_sqpos_q;
        ent_tag_d   = ent_tag_q;
        if (squash) begin
            state_d = ST_IDLE;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_s) begin
                ent_store_d[tail_q] = in_is_store;
                ent_addr_d[tail_q]  = eff_addr_s;
                ent_data_d[tail_q]  = in_data;
                ent_size_d[tail_q]  = in_size;
                ent_sqpos_d[tail_q] = in_sq_pos;
                ent_tag_d[tail_q]   = in_tag;
                tail_d              = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // A freshly pushed entry may be requested on the very next cycle.
            case (state_q)
                ST_IDLE: begin
                    if ((count_q != '0) || push_s) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (lsq_req_ready) begin
                        state_d = ent_store_q[head_q] ? ST_DONE : ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (lsq_resp_valid) begin
                        load_data_d = lsq_resp_data;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_d = (count_q > CNT_W'(1)) ? ST_REQ : ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            load_data_q <= load_data_d;
        end
    end

    // Entry payload storage; contents are only observed through valid pointers.
    always_ff @(posedge clock) begin
        ent_store_q <= ent_store_d;
        ent_addr_q  <= ent_addr_d;
        ent_data_q  <= ent_data_d;
        ent_size_q  <= ent_size_d;
        ent_sqpos_q <= ent_sqpos_d;
        ent_tag_q   <= ent_tag_d;
    end

    // Data outputs are forced to zero whenever their valid is low.
    assign lsq_req_valid  = req_valid_s;
    assign lsq_req_store  = req_valid_s ? ent_store_q[head_q] : 1'b0;
    assign lsq_req_addr   = req_valid_s ? ent_addr_q[head_q]  : '0;
    assign lsq_req_data   = req_valid_s ? ent_data_q[head_q]  : '0;
    assign lsq_req_size   = req_valid_s ? ent_size_q[head_q]  : 2'b00;
    assign lsq_req_sq_pos = req_valid_s ? ent_sqpos_q[head_q] : '0;
    assign res_valid      = res_valid_s;
    assign res_tag        = res_valid_s ? ent_tag_q[head_q]   : '0;
    assign res_is_store   = res_valid_s ? ent_store_q[head_q] : 1'b0;
    assign res_value      = (res_valid_s && !ent_store_q[head_q]) ? load_data_q : '0;

endmodule

// File: tb/tb_fu_ls_pipe.sv
// Directed bench for fu_ls_pipe: a queue-based reference model is compared
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_fu_ls_pipe;
    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [31:0] in_base;
    logic [11:0] in_imm;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic [2:0]  in_sq_pos;
    logic [4:0]  in_tag;
    logic        squash;
    logic        lsq_req_valid;
    logic        lsq_req_ready;
    logic        lsq_req_store;
    logic [31:0] lsq_req_addr;
    logic [31:0] lsq_req_data;
    logic [1:0]  lsq_req_size;
    logic [2:0]  lsq_req_sq_pos;
    logic        lsq_resp_valid;
    logic [31:0] lsq_resp_data;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_tag;
    logic [31:0] res_value;
    logic        res_is_store;

    fu_ls_pipe #(.XLEN(32), .DEPTH(4), .SQ_IDX_W(3), .TAG_W(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_base(in_base), .in_imm(in_imm), .in_data(in_data), .in_size(in_size),
        .in_sq_pos(in_sq_pos), .in_tag(in_tag), .squash(squash),
        .lsq_req_valid(lsq_req_valid), .lsq_req_ready(lsq_req_ready),
        .lsq_req_store(lsq_req_store), .lsq_req_addr(lsq_req_addr),
        .lsq_req_data(lsq_req_data), .lsq_req_size(lsq_req_size),
        .lsq_req_sq_pos(lsq_req_sq_pos), .lsq_resp_valid(lsq_resp_valid),
        .lsq_resp_data(lsq_resp_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_tag(res_tag), .res_value(res_value), .res_is_store(res_is_store)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [2:0]  sqp;
        logic [4:0]  tag;
    } op_t;

    op_t         mq[$];
    bit          m_req, m_wait, m_done;
    logic [31:0] m_ldata;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    bit          rec_en = 1'b0;
    logic [4:0]  rec_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input bit st, input logic [31:0] base, input logic [11:0] imm,
                            input logic [31:0] data, input logic [1:0] size,
                            input logic [2:0] sqp, input logic [4:0] tag);
        in_valid    = 1'b1;
        in_is_store = st;
        in_base     = base;
        in_imm      = imm;
        in_data     = data;
        in_size     = size;
        in_sq_pos   = sqp;
        in_tag      = tag;
    endtask

    // Reference model: ops travel request -> (response) -> completion in program order.
    initial begin
        forever begin
            @(posedge clock);
            if (reset || squash) begin
                mq.delete();
                m_req  = 1'b0;
                m_wait = 1'b0;
                m_done = 1'b0;
            end else begin
                automatic bit  do_push = in_valid && (mq.size() < 4);
                automatic op_t n;
                if (m_req) begin
                    if (lsq_req_ready) begin
                        m_req = 1'b0;
                        if (mq[0].st) m_done = 1'b1;
                        else m_wait = 1'b1;
                    end
                end else if (m_wait) begin
                    if (lsq_resp_valid) begin
                        m_wait  = 1'b0;
                        m_done  = 1'b1;
                        m_ldata = lsq_resp_data;
                    end
                end else if (m_done) begin
                    if (res_ready) begin
                        m_done = 1'b0;
                        void'(mq.pop_front());
                        if (mq.size() > 0) m_req = 1'b1;
                    end
                end else if (mq.size() > 0 || do_push) begin
                    m_req = 1'b1;
                end
                if (do_push) begin
                    n.st   = in_is_store;
                    n.addr = in_base + {{20{in_imm[11]}}, in_imm};
                    n.data = in_data;
                    n.size = in_size;
                    n.sqp  = in_sq_pos;
                    n.tag  = in_tag;
                    mq.push_back(n);
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (rec_en && res_valid && res_ready) rec_q.push_back(res_tag);
            if (mon_en) begin
                check("m_in_ready", in_ready, (mq.size() < 4) ? 32'd1 : 32'd0);
                check("m_req_valid", lsq_req_valid, m_req);
                check("m_res_valid", res_valid, m_done);
                if (m_req) begin
                    check("m_req_store", lsq_req_store, mq[0].st);
                    check("m_req_addr", lsq_req_addr, mq[0].addr);
                    check("m_req_data", lsq_req_data, mq[0].data);
                    check("m_req_size", lsq_req_size, mq[0].size);
                    check("m_req_sqpos", lsq_req_sq_pos, mq[0].sqp);
                end
                if (m_done) begin
                    check("m_res_tag", res_tag, mq[0].tag);
                    check("m_res_store", res_is_store, mq[0].st);
                    check("m_res_value", res_value, mq[0].st ? 32'd0 : m_ldata);
                end
            end
        end
    end

    initial begin
        logic [31:0] held_addr;
        logic [4:0]  exp_tags [4];
        reset = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_base = 32'd0;
        in_imm = 12'd0; in_data = 32'd0; in_size = 2'd0; in_sq_pos = 3'd0;
        in_tag = 5'd0; squash = 1'b0; lsq_req_ready = 1'b0; lsq_resp_valid = 1'b0;
        lsq_resp_data = 32'd0; res_ready = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        check("rst_in_ready", in_ready, 32'd1);
        check("rst_req_valid", lsq_req_valid, 32'd0);
        check("rst_res_valid", res_valid, 32'd0);
        check("rst_req_addr", lsq_req_addr, 32'd0);
        check("rst_res_value", res_value, 32'd0);
        reset = 1'b0;
        step();

        // Load: 0x1000 + sext(0xFFC) = 0x0FFC
        drive_op(1'b0, 32'h0000_1000, 12'hFFC, 32'd0, 2'd2, 3'd1, 5'd1);
        step();
        in_valid = 1'b0;
        check("ld_req_valid", lsq_req_valid, 32'd1);
        check("ld_addr", lsq_req_addr, 32'h0000_0FFC);
        lsq_req_ready = 1'b1;
        step();
        lsq_req_ready = 1'b0;
        lsq_resp_valid = 1'b1; lsq_resp_data = 32'hDEAD_BEEF;
        step();
        lsq_resp_valid = 1'b0;
        check("ld_res_valid", res_valid, 32'd1);
        check("ld_res_value", res_value, 32'hDEAD_BEEF);
        check("ld_res_store", res_is_store, 32'd0);
        check("ld_res_tag", res_tag, 32'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("ld_popped", res_valid, 32'd0);

        // Store: 0x2000 + 0x010
        drive_op(1'b1, 32'h0000_2000, 12'h010, 32'h0000_0055, 2'd2, 3'd5, 5'd2);
        step();
        in_valid = 1'b0;
        check("st_addr", lsq_req_addr, 32'h0000_2010);
        check("st_data", lsq_req_data, 32'h0000_0055);
        check("st_sqpos", lsq_req_sq_pos, 32'd5);
        check("st_store", lsq_req_store, 32'd1);
        lsq_req_ready = 1'b1;
        step();
        lsq_req_ready = 1'b0;
        check("st_res_valid", res_valid, 32'd1);
        check("st_res_value", res_value, 32'd0);
        check("st_res_store", res_is_store, 32'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Address wrap: 0xFFFFFFF0 + 0x20 = 0x10
        drive_op(1'b0, 32'hFFFF_FFF0, 12'h020, 32'd0, 2'd0, 3'd0, 5'd3);
        step();
        in_valid = 1'b0;
        check("wrap_addr", lsq_req_addr, 32'h0000_0010);
        lsq_req_ready = 1'b1;
        step();
        lsq_req_ready = 1'b0;
        lsq_resp_valid = 1'b1; lsq_resp_data = 32'h1234_5678;
        step();
        lsq_resp_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Fill the buffer under request backpressure, then drain in tag order.
        for (int i = 0; i < 4; i++) begin
            drive_op(i[0], 32'h0000_4000, 12'(i * 4), 32'(100 + i), 2'd2, 3'(i), 5'(4 + i));
            step();
        end
        check("full_in_ready", in_ready, 32'd0);
        drive_op(1'b0, 32'h0000_5000, 12'd0, 32'd0, 2'd2, 3'd0, 5'd8);
        step();
        in_valid = 1'b0;
        check("full_reject", in_ready, 32'd0);
        rec_en = 1'b1;
        lsq_req_ready = 1'b1; res_ready = 1'b1; lsq_resp_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            lsq_resp_data = 32'hA000_0000 + 32'(i);
            step();
        end
        lsq_req_ready = 1'b0; res_ready = 1'b0; lsq_resp_valid = 1'b0;
        rec_en = 1'b0;
        check("drain_in_ready", in_ready, 32'd1);
        check("drain_count", rec_q.size(), 32'd4);
        exp_tags[0] = 5'd4; exp_tags[1] = 5'd5; exp_tags[2] = 5'd6; exp_tags[3] = 5'd7;
        for (int i = 0; i < 4; i++) begin
            if (i < rec_q.size()) check("drain_order", rec_q[i], exp_tags[i]);
        end

        // Backpressure on request then on result.
        drive_op(1'b0, 32'h0000_6000, 12'h004, 32'd0, 2'd1, 3'd2, 5'd9);
        step();
        in_valid = 1'b0;
        held_addr = 32'h0000_6004;
        for (int i = 0; i < 5; i++) begin
            check("bp_req_valid", lsq_req_valid, 32'd1);
            check("bp_req_addr", lsq_req_addr, held_addr);
            check("bp_req_size", lsq_req_size, 32'd1);
            step();
        end
        lsq_req_ready = 1'b1;
        step();
        lsq_req_ready = 1'b0;
        lsq_resp_valid = 1'b1; lsq_resp_data = 32'hCAFE_F00D;
        step();
        lsq_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_res_valid", res_valid, 32'd1);
            check("bp_res_value", res_value, 32'hCAFE_F00D);
            check("bp_res_tag", res_tag, 32'd9);
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_no_dup", res_valid, 32'd0);
        step();
        check("bp_no_dup2", res_valid, 32'd0);

        // Squash with head in WAIT and three entries; late response must be dropped.
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b0, 32'h0000_7000, 12'(i * 8), 32'd0, 2'd2, 3'd0, 5'(10 + i));
            step();
        end
        in_valid = 1'b0;
        lsq_req_ready = 1'b1;
        step();
        lsq_req_ready = 1'b0;
        squash = 1'b1;
        drive_op(1'b0, 32'h0000_8000, 12'd0, 32'd0, 2'd2, 3'd0, 5'd14);
        step();
        squash = 1'b0; in_valid = 1'b0;
        lsq_resp_valid = 1'b1; lsq_resp_data = 32'h0000_0077;
        step();
        lsq_resp_valid = 1'b0;
        check("sq_res_valid", res_valid, 32'd0);
        check("sq_in_ready", in_ready, 32'd1);
        check("sq_req_valid", lsq_req_valid, 32'd0);
        step();
        check("sq_res_valid2", res_valid, 32'd0);

        // Reset while waiting for a load response.
        drive_op(1'b0, 32'h0000_3000, 12'd0, 32'd0, 2'd2, 3'd0, 5'd13);
        step();
        in_valid = 1'b0;
        lsq_req_ready = 1'b1;
        step();
        lsq_req_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        lsq_resp_valid = 1'b1; lsq_resp_data = 32'h0000_0099;
        step();
        lsq_resp_valid = 1'b0;
        check("mr_res_valid", res_valid, 32'd0);
        check("mr_req_valid", lsq_req_valid, 32'd0);
        check("mr_in_ready", in_ready, 32'd1);
        step();
        step();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
